// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding,
// parity-mode constants and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 8;

  // Parity over a zero-extended payload; zeros
  // above the real width do not change the XOR.
  function automatic logic parity_of(
    input logic [MAX_DATA_BITS-1:0] d,
    input logic                     mode
  );
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1,
// flags the last cycle of each bit and wraps.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign bit_tick = (r_cnt == LAST);

  // count within a bit, wrap at the bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter fed from a registered-read FIFO:
// fetch, load, then shift out start/data/parity/stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] LAST_DATA =
    BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP =
    BW'(STOP_BITS - 1);

  localparam logic P_MODE =
    (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic HAS_PAR = (PARITY_EN != 0);

  uart_state_e r_state;
  uart_state_e w_next;

  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_par;
  logic                 r_armed;

  logic w_tick;
  logic w_clear;
  logic w_last_data;
  logic w_last_stop;
  logic w_tx;
  logic w_rd;
  logic w_busy;
  logic w_done;

  logic [MAX_DATA_BITS-1:0] w_data8;

  // zero-extend payload for the shared parity helper
  always_comb begin
    w_data8 = '0;
    w_data8[DATA_BITS-1:0] = fifo_data;
  end

  assign w_last_data = (r_bit_cnt == LAST_DATA);
  assign w_last_stop = (r_bit_cnt == LAST_STOP);

  // hold the bit timer at zero until the frame starts
  assign w_clear = (r_state == ST_IDLE)  ||
                   (r_state == ST_FETCH) ||
                   (r_state == ST_LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .bit_tick (w_tick)
  );

  // one-cycle hold-off after reset before fetching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and outputs, decoded from registers
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    w_rd   = 1'b0;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (r_armed && !fifo_empty) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rd   = 1'b1;
        w_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_START;
      end
      ST_START: begin
        w_tx = 1'b0;
        if (w_tick) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx = r_shift[0];
        if (w_tick && w_last_data) begin
          w_next = HAS_PAR ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_tx = r_par;
        if (w_tick) begin
          w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick && w_last_stop) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // payload shift register, bit/stop counter, parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift   <= fifo_data;
          r_bit_cnt <= '0;
          r_par     <= parity_of(w_data8, P_MODE);
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (w_last_data) begin
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (w_last_stop) begin
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tx         = w_tx;
  assign fifo_rd_en = w_rd;
  assign busy       = w_busy;
  assign frame_done = w_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configured lanes,
// FIFO models, scoreboard of queued bytes.
module tb_uart_tx_engine;

  localparam int CPB[4] = '{4, 4, 4, 16};
  localparam int PE[4]  = '{0, 1, 1, 0};
  localparam int PO[4]  = '{0, 0, 1, 0};
  localparam int SB[4]  = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fe;
  logic [3:0] rd;
  logic [3:0] txs;
  logic [3:0] bsy;
  logic [3:0] dn;
  logic [7:0] fd [4];

  logic [7:0] mem [4][64];
  int n_push [4] = '{0, 0, 0, 0};
  int n_pop  [4] = '{0, 0, 0, 0};
  int rdcnt  [4] = '{0, 0, 0, 0};

  typedef struct {
    int         lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       xpar;
    int         xlen;
  } vec_t;

  vec_t tbl [9];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .CLKS_PER_BIT (4)
  ) u_a (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fe[0]),
    .fifo_data  (fd[0]),
    .fifo_rd_en (rd[0]),
    .tx         (txs[0]),
    .busy       (bsy[0]),
    .frame_done (dn[0])
  );

  uart_tx_engine #(
    .CLKS_PER_BIT (4),
    .PARITY_EN    (1),
    .PARITY_ODD   (0)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fe[1]),
    .fifo_data  (fd[1]),
    .fifo_rd_en (rd[1]),
    .tx         (txs[1]),
    .busy       (bsy[1]),
    .frame_done (dn[1])
  );

  uart_tx_engine #(
    .CLKS_PER_BIT (4),
    .PARITY_EN    (1),
    .PARITY_ODD   (1)
  ) u_c (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fe[2]),
    .fifo_data  (fd[2]),
    .fifo_rd_en (rd[2]),
    .tx         (txs[2]),
    .busy       (bsy[2]),
    .frame_done (dn[2])
  );

  uart_tx_engine #(
    .CLKS_PER_BIT (16),
    .STOP_BITS    (2)
  ) u_d (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fe[3]),
    .fifo_data  (fd[3]),
    .fifo_rd_en (rd[3]),
    .tx         (txs[3]),
    .busy       (bsy[3]),
    .frame_done (dn[3])
  );

  for (genvar g = 0; g < 4; g++) begin : g_fe
    assign fe[g] = (n_push[g] == n_pop[g]);
  end

  // FIFO models: registered read data, read-strobe count
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        fd[i]    <= mem[i][n_pop[i]];
        n_pop[i] <= n_pop[i] + 1;
        rdcnt[i] <= rdcnt[i] + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int l, input logic [7:0] d);
    exp_t e;
    mem[l][n_push[l]] = d;
    n_push[l] = n_push[l] + 1;
    e.lane = l;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // expected serial bit sequence, start bit first
  function automatic logic [15:0] model(
    input logic [7:0] d,
    input int         l
  );
    logic [15:0] b;
    logic        po;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    po = (PO[l] != 0);
    if (PE[l] != 0) b[9] = (^d) ^ po;
    return b;
  endfunction

  // receive one frame, starting at current negedge
  task automatic rx_frame(
    input int   l,
    input logic xpar,
    input int   xlen
  );
    exp_t        e;
    logic [15:0] bits;
    logic [15:0] got;
    int cpb, len, t, bad, done_at;
    cpb = CPB[l];
    len = (1 + 8 + PE[l] + SB[l]) * cpb;
    t = 0;
    while (txs[l] !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (txs[l] !== 1'b0) begin
      check("start_timeout", 32'(t), 32'd0);
      return;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e    = sb_q.pop_front();
    bits = model(e.data, l);
    got  = '1;
    bad  = -1;
    done_at = -1;
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (bad < 0 && (txs[l] !== bits[c/cpb] ||
          rd[l] !== 1'b0 || bsy[l] !== 1'b1))
        bad = c;
      if (done_at < 0 && dn[l] === 1'b1)
        done_at = c;
      if (c % cpb == cpb / 2)
        got[c/cpb] = txs[l];
    end
    check("lane", 32'(e.lane), 32'(l));
    check("data", 32'(got[8:1]), 32'(e.data));
    check("wave_first_bad_cycle", 32'(bad), 32'hFFFF_FFFF);
    check("frame_len", 32'(done_at + 1), 32'(xlen));
    if (PE[l] != 0)
      check("parity", 32'(got[9]), 32'(xpar));
  endtask

  initial begin
    int r0, gap, flag;

    tbl[0] = '{0, 8'hA5, 1'b0, 40};
    tbl[1] = '{0, 8'h00, 1'b0, 40};
    tbl[2] = '{0, 8'hFF, 1'b0, 40};
    tbl[3] = '{0, 8'h3C, 1'b0, 40};
    tbl[4] = '{1, 8'hA5, 1'b0, 44};
    tbl[5] = '{1, 8'h07, 1'b1, 44};
    tbl[6] = '{2, 8'hA5, 1'b1, 44};
    tbl[7] = '{2, 8'h07, 1'b0, 44};
    tbl[8] = '{3, 8'hFF, 1'b0, 176};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(txs), 32'hF);
    check("rst_busy", 32'(bsy), 32'h0);
    check("rst_rd",   32'(rd),  32'h0);
    check("rst_done", 32'(dn),  32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      r0 = rdcnt[tbl[v].lane];
      push(tbl[v].lane, tbl[v].data);
      rx_frame(tbl[v].lane, tbl[v].xpar, tbl[v].xlen);
      check("rd_pulses", 32'(rdcnt[tbl[v].lane] - r0),
            32'd1);
      @(negedge clk);
    end

    // back-to-back frames and inter-frame gap
    r0 = rdcnt[0];
    push(0, 8'h11);
    push(0, 8'h22);
    rx_frame(0, 1'b0, 40);
    gap = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (txs[0] === 1'b0) break;
      gap++;
    end
    check("gap", 32'(gap), 32'd3);
    rx_frame(0, 1'b0, 40);
    check("b2b_rd_pulses", 32'(rdcnt[0] - r0), 32'd2);
    @(negedge clk);

    // empty FIFO: line stays idle
    flag = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txs !== 4'hF || bsy !== 4'h0 || rd !== 4'h0)
        flag = 1;
    end
    check("idle_100", 32'(flag), 32'd0);

    // reset during data bit 3, then a full frame
    r0 = rdcnt[0];
    push(0, 8'hA5);
    push(0, 8'hC3);
    gap = 0;
    while (txs[0] !== 1'b0 && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    repeat (17) @(negedge clk);
    check("pre_rst_bit3", 32'(txs[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_tx",   32'(txs[0]), 32'd1);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    void'(sb_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rd_after_1st_edge", 32'(rd[0]), 32'd0);
    rx_frame(0, 1'b0, 40);
    check("abort_rd_pulses", 32'(rdcnt[0] - r0), 32'd2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter DATA_BITS, 8, payload bits per frame (5..8).
REQ-002 Parameter CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
REQ-003 Parameter PARITY_EN, 0, 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, 0, 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, 1, number of stop bits (1 or 2).
REQ-006 Port clk  in  1  clock; all state changes on rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port fifo_empty  in  1  upstream FIFO empty flag.
REQ-009 Port fifo_data  in  DATA_BITS  upstream FIFO registered read data, valid one cycle after a read strobe.
REQ-010 Port fifo_rd_en  out  1  read strobe to the upstream FIFO.
REQ-011 Port tx  out  1  serial line, idle high.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port frame_done  out  1  single-cycle pulse marking the end of a frame.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-015 IDLE with fifo_empty=0 SHALL go to FETCH on the next edge; with fifo_empty=1 it SHALL remain in IDLE.
REQ-016 fifo_rd_en SHALL be 1 only in FETCH, for exactly one cycle per frame, and never while fifo_empty=1 was sampled in IDLE.
REQ-017 FETCH SHALL go unconditionally to LOAD.
REQ-018 LOAD SHALL capture fifo_data into the shift register, clear the bit counter and baud counter, and go to START.
REQ-019 tx SHALL be 1 in IDLE, FETCH and LOAD.
REQ-020 In START, tx SHALL be 0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-021 In DATA, tx SHALL output shift-register bit 0 (LSB first), each bit held for CLKS_PER_BIT cycles, with a shift right at each bit boundary.
REQ-022 DATA SHALL exit after DATA_BITS bits, to PARITY if PARITY_EN=1 and to STOP otherwise.
REQ-023 The parity bit SHALL be the XOR of the captured bits, inverted when PARITY_ODD=1, and SHALL be held for CLKS_PER_BIT cycles.
REQ-024 In STOP, tx SHALL be 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-025 frame_done SHALL pulse on the last cycle of STOP, and the FSM SHALL then return to IDLE.
REQ-026 Frame length SHALL be (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-027 The gap from frame_done to the next start bit SHALL be 3 cycles (IDLE, FETCH, LOAD) when data is waiting.
REQ-028 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-029 The bit counter SHALL be $clog2(DATA_BITS+1) bits wide.
REQ-030 fifo_empty changes during a frame SHALL have no effect until IDLE.
REQ-031 fifo_data SHALL be sampled only in LOAD.
REQ-032 tx, fifo_rd_en and frame_done SHALL be glitch-free, decoded from registered state only.

Reset
REQ-033 While rst=1: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, and all counters and the shift register=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, driving tx high asynchronously with no partial stop bit, and the byte SHALL be lost.
REQ-035 After rst deasserts, the first fifo_rd_en SHALL occur no earlier than the second rising edge.

Structure
REQ-036 State encoding and parity-mode constants SHALL reside in shared package uart_pkg, which the future uart_rx_engine also uses.
REQ-037 One sub-module, uart_baud_counter, SHALL be used; it takes clk, rst and clear, and produces bit_tick at count CLKS_PER_BIT-1.
REQ-038 All other logic SHALL be flat within uart_tx_engine.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-039 Stimulus: one byte 0xA5, no parity, 1 stop. Required: tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; frame_done 40 cycles after the start-bit edge; one fifo_rd_en.
REQ-040 Stimulus: PARITY_EN=1, even, byte 0xA5. Required: parity bit 0. Stimulus: byte 0x07. Required: parity bit 1. With PARITY_ODD=1, both parity bits are inverted.
REQ-041 Stimulus: bytes 0x11 and 0x22 queued back-to-back. Required: two frames, exactly 3 tx-high cycles between stop end and the second start bit, and two fifo_rd_en pulses.
REQ-042 Stimulus: fifo_empty=1 held for 100 cycles. Required: tx=1, busy=0, fifo_rd_en never 1.
REQ-043 Stimulus: rst asserted in DATA bit 3. Required: tx=1 in the same cycle, busy=0, and after release the next queued byte is sent as a full frame.
REQ-044 Stimulus: STOP_BITS=2, CLKS_PER_BIT=16, byte 0xFF. Required: stop phase lasts 32 cycles and the frame lasts 176 cycles.
